ff_inv_seq: RTL and testbench

//  Sequencer that computes GF(2^NUM_BITS) exponentiation din^EXP by square-and-multiply,

---
 rtl/ff_inv_seq_if.sv | 24 ++
 rtl/ff_inv_seq.sv | 135 +++++++++++++
 tb/tb_ff_inv_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ff_inv_seq_if.sv
// Handshake, result and ff_mult operand bundle between ff_inv_seq and its user.
// The user side (master) launches operations and also hosts the shared ff_mult.
interface ff_inv_seq_if #(
  parameter int NUM_BITS = 8
);
  logic                    start;
  logic [NUM_BITS-1:0]     din;
  logic                    busy;
  logic                    done;
  logic [NUM_BITS-1:0]     dout;
  logic [NUM_BITS-1:0]     mult_a;
  logic [NUM_BITS-1:0]     mult_b;
  logic [2*NUM_BITS-2:0]   mult_p;

  modport master (
    output start, din, mult_p,
    input  busy, done, dout, mult_a, mult_b
  );

  modport slave (
    input  start, din, mult_p,
    output busy, done, dout, mult_a, mult_b
  );
endinterface

// File: rtl/ff_inv_seq.sv
// GF(2^NUM_BITS) exponentiation din^EXP by MSB-first square-and-multiply, time-sharing
// one external combinational ff_mult. EXP=254 gives the AES S-box inverse (inv(0)=0).
module ff_inv_seq #(
  parameter int                  NUM_BITS = 8,
  parameter logic [NUM_BITS:0]   POLY     = 9'h11B,
  parameter logic [NUM_BITS-1:0] EXP      = 8'hFE
) (
  input  logic         clk,
  input  logic         rst,
  ff_inv_seq_if.slave  bus
);

  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int PW    = 2*NUM_BITS-1;

  localparam logic [IDX_W-1:0]    IDX_TOP = IDX_W'(NUM_BITS-1);
  localparam logic [NUM_BITS-1:0] ONE     = NUM_BITS'(1);
  localparam logic [PW-1:0]       POLY_X  = PW'(POLY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    MULT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_BITS-1:0] acc, base, dout_q;
  logic [IDX_W-1:0]    idx;
  logic [NUM_BITS-1:0] op_a, op_b;
  logic                busy_o, done_o;
  logic [NUM_BITS-1:0] prod_red;
  logic                exp_bit, idx_zero, launch;

  // Long-division reduction, top bit down. A product already below x^NUM_BITS
  // passes through unchanged, so reduced and unreduced ff_mult flavours both work.
  function automatic logic [NUM_BITS-1:0] red(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int i = PW-1; i >= NUM_BITS; i--) begin
      if (r[i]) r = r ^ (POLY_X << (i - NUM_BITS));
    end
    return r[NUM_BITS-1:0];
  endfunction

  assign prod_red = red(bus.mult_p);
  assign exp_bit  = EXP[idx];
  assign idx_zero = (idx == '0);
  assign launch   = bus.start && !busy_o;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = bus.start ? SQUARE : IDLE;
      SQUARE: begin
        if (exp_bit)       state_nxt = MULT;
        else if (idx_zero) state_nxt = DONE;
        else               state_nxt = SQUARE;
      end
      MULT:    state_nxt = idx_zero ? DONE : SQUARE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state)
      SQUARE: begin
        op_a   = acc;
        op_b   = acc;
        busy_o = 1'b1;
      end
      MULT: begin
        op_a   = acc;
        op_b   = base;
        busy_o = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // idx only steps when the bit just processed is finished; a set bit holds idx
  // across SQUARE->MULT so the multiply belongs to the same exponent bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      base   <= '0;
      idx    <= '0;
      dout_q <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (launch) begin
            base <= bus.din;
            acc  <= ONE;
            idx  <= IDX_TOP;
          end
        end
        SQUARE: begin
          acc <= prod_red;
          if (!exp_bit) begin
            if (idx_zero) dout_q <= prod_red;
            else          idx    <= idx - 1'b1;
          end
        end
        MULT: begin
          acc <= prod_red;
          if (idx_zero) dout_q <= prod_red;
          else          idx    <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mult_a = op_a;
  assign bus.mult_b = op_b;
  assign bus.busy   = busy_o;
  assign bus.done   = done_o;
  assign bus.dout   = dout_q;

endmodule

// File: tb/tb_ff_inv_seq.sv
// Directed bench for ff_inv_seq: latency, known inverses, busy-ignore, back-to-back,
// mid-op reset and an exhaustive sweep against a brute-force GF(2^8) inverse.
module tb_ff_inv_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  ff_inv_seq_if #(.NUM_BITS(8)) bus ();

  ff_inv_seq #(.NUM_BITS(8), .POLY(9'h11B), .EXP(8'hFE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // external ff_mult: unreduced carry-less product
  function automatic logic [14:0] clmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (b[i]) r = r ^ (15'(a) << i);
    return r;
  endfunction

  assign bus.mult_p = clmul(bus.mult_a, bus.mult_b);

  // reference: AES GF multiply via xtime, inverse by exhaustive search
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, r;
    x = a; y = b; r = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    logic [7:0] res;
    res = '0;
    for (int y = 1; y < 256; y++) if (gmul(a, 8'(y)) == 8'h01) res = 8'(y);
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns one negedge after the accepting edge, with din scrambled
  task automatic go(input logic [7:0] d);
    bus.start = 1'b1;
    bus.din   = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = ~d;
  endtask

  // counts cycles from the accepting edge to the done pulse, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] d, input logic [7:0] want);
    int lat;
    go(d);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd15);
    chk({tag, "_dout"}, 32'(bus.dout), 32'(want));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat, pulses, first;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.din   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_ma",   32'(bus.mult_a), 32'd0);
    chk("rst_mb",   32'(bus.mult_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("v53", 8'h53, 8'hCA);
    run("v02", 8'h02, 8'h8D);
    run("v01", 8'h01, 8'h01);
    run("v00", 8'h00, 8'h00);

    // start during busy is dropped
    go(8'h53);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3) begin bus.start = 1'b1; bus.din = 8'h02; end
      else bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_lat",    32'(first),  32'd15);
    chk("ign_dout",   32'(bus.dout), 32'hCA);

    // relaunch straight out of DONE
    go(8'h53);
    wait_done(lat);
    chk("b2b_lat0",  32'(lat), 32'd15);
    chk("b2b_dout0", 32'(bus.dout), 32'hCA);
    go(8'hCA);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("b2b_lat1",  32'(lat), 32'd15);
    chk("b2b_dout1", 32'(bus.dout), 32'h53);
    @(negedge clk);

    // reset mid-operation
    go(8'h53);
    for (int c = 1; c < 7; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_dout", 32'(bus.dout), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("mrst_nodone", 32'(pulses), 32'd0);
    chk("mrst_ma",     32'(bus.mult_a), 32'd0);
    run("mrst_v53", 8'h53, 8'hCA);

    // exhaustive sweep
    for (int x = 0; x < 256; x++) begin
      go(8'(x));
      wait_done(lat);
      chk($sformatf("sweep_%02h", x), 32'(bus.dout), 32'(ref_inv(8'(x))));
      @(negedge clk);
    end
    chk("idle_ma", 32'(bus.mult_a), 32'd0);
    chk("idle_mb", 32'(bus.mult_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
